// File: rtl/dual_port_regfile.sv
// Architectural register file: two writeback ports with same-cycle bypass,
// four combinational read ports and a per-register pending scoreboard.
module dual_port_regfile #(
  parameter int NREG = 32,
  parameter int DW   = 32,
  localparam int AW  = $clog2(NREG)
) (
  input  logic          clock2,
  input  logic          reset_n,
  input  logic [1:0]    wb_en,
  input  logic [AW-1:0] wb_addr1,
  input  logic [AW-1:0] wb_addr2,
  input  logic [DW-1:0] wb_data1,
  input  logic [DW-1:0] wb_data2,
  input  logic [AW-1:0] rd_addr [4],
  output logic [DW-1:0] rd_data [4],
  input  logic [1:0]    issue_en,
  input  logic [AW-1:0] issue_dest1,
  input  logic [AW-1:0] issue_dest2,
  output logic [3:0]    rd_busy,
  output logic          stall
);

  logic [DW-1:0]   regs_q [NREG];
  logic [DW-1:0]   regs_d [NREG];
  logic [NREG-1:0] pend_q;
  logic [NREG-1:0] pend_d;
  logic [NREG-1:0] wr_hit1;
  logic [NREG-1:0] wr_hit2;
  logic [NREG-1:0] set_hit;

  // Per-register next state: port 2 wins a write conflict, issue set wins over writeback clear.
  for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
    assign wr_hit1[gi] = wb_en[0] && (wb_addr1 == AW'(gi));
    assign wr_hit2[gi] = wb_en[1] && (wb_addr2 == AW'(gi));
    assign set_hit[gi] = (issue_en[0] && (issue_dest1 == AW'(gi))) ||
                         (issue_en[1] && (issue_dest2 == AW'(gi)));

    if (gi == 0) begin : g_zero
      assign regs_d[gi] = '0;
      assign pend_d[gi] = 1'b0;
    end else begin : g_nonzero
      assign regs_d[gi] = wr_hit2[gi] ? wb_data2 :
                          wr_hit1[gi] ? wb_data1 : regs_q[gi];
      assign pend_d[gi] = set_hit[gi] ||
                          (pend_q[gi] && !(wr_hit1[gi] || wr_hit2[gi]));
    end
  end

  always_ff @(posedge clock2 or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < NREG; r++) begin
        regs_q[r] <= '0;
      end
      pend_q <= '0;
    end else begin
      regs_q <= regs_d;
      pend_q <= pend_d;
    end
  end

  // Read ports: a write in flight this cycle both supplies the data and masks pending.
  for (genvar gi = 0; gi < 4; gi++) begin : g_rd
    logic byp1;
    logic byp2;

    assign byp1 = wb_en[0] && (wb_addr1 == rd_addr[gi]);
    assign byp2 = wb_en[1] && (wb_addr2 == rd_addr[gi]);

    assign rd_data[gi] = (rd_addr[gi] == '0) ? '0 :
                         byp2 ? wb_data2 :
                         byp1 ? wb_data1 : regs_q[rd_addr[gi]];
    assign rd_busy[gi] = pend_q[rd_addr[gi]] && !(byp1 || byp2);
  end

  assign stall = (issue_en[0] && (|rd_busy[1:0])) ||
                 (issue_en[1] && (|rd_busy[3:2]));

endmodule
